wb_arbiter: RTL and testbench



---
 rtl/wb_arbiter.sv | 123 ++++++++++++
 tb/tb_wb_arbiter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// Writeback arbiter: five producers, each with a one-entry holding slot, share the single
// ROB result port through a round-robin scheduler and a registered ready/valid output stage.
module wb_arbiter #(
  parameter int N_REQ  = 5,
  parameter int TAG_W  = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [N_REQ*TAG_W-1:0]  req_tag,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  input  logic [N_REQ*ADDR_W-1:0] req_addr,
  input  logic                    flush,
  output logic                    wb_valid,
  input  logic                    wb_ready,
  output logic [2:0]              wb_src,
  output logic [TAG_W-1:0]        wb_tag,
  output logic [DATA_W-1:0]       wb_data,
  output logic [ADDR_W-1:0]       wb_addr
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0]  r_full;
  logic [TAG_W-1:0]  r_tag  [N_REQ];
  logic [DATA_W-1:0] r_data [N_REQ];
  logic [ADDR_W-1:0] r_addr [N_REQ];
  logic [PTR_W-1:0]  r_ptr;

  logic              r_wb_valid;
  logic [2:0]        r_wb_src;
  logic [TAG_W-1:0]  r_wb_tag;
  logic [DATA_W-1:0] r_wb_data;
  logic [ADDR_W-1:0] r_wb_addr;

  logic              w_free;
  logic              w_arb;
  logic [N_REQ-1:0]  w_grant;
  logic              w_any;
  logic [PTR_W-1:0]  w_idx;
  logic [PTR_W-1:0]  w_ptr_nxt;
  logic [N_REQ-1:0]  w_cap;

  assign w_free = !r_wb_valid || wb_ready;
  assign w_arb  = w_free && !flush;

  // Rotating priority search starting at r_ptr; first full slot wins.
  always_comb begin
    int j;
    j       = 0;
    w_grant = '0;
    w_any   = 1'b0;
    w_idx   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      j = int'(r_ptr) + k;
      if (j >= N_REQ) j = j - N_REQ;
      if (w_arb && !w_any && r_full[j]) begin
        w_any      = 1'b1;
        w_idx      = PTR_W'(j);
        w_grant[j] = 1'b1;
      end
    end
  end

  assign w_ptr_nxt = (w_idx == PTR_W'(N_REQ - 1)) ? '0 : w_idx + PTR_W'(1);

  // A slot being granted this cycle frees up, so it may be refilled on the same edge.
  assign req_ready = {N_REQ{!flush}} & (~r_full | w_grant);
  assign w_cap     = req_valid & req_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_full <= '0;
      r_ptr  <= '0;
    end else if (flush) begin
      r_full <= '0;
    end else begin
      r_full <= (r_full & ~w_grant) | w_cap;
      if (w_any) r_ptr <= w_ptr_nxt;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < N_REQ; i++) begin
      if (w_cap[i]) begin
        r_tag[i]  <= req_tag[i*TAG_W +: TAG_W];
        r_data[i] <= req_data[i*DATA_W +: DATA_W];
        r_addr[i] <= req_addr[i*ADDR_W +: ADDR_W];
      end
    end
  end

  // Output stage: loads on a grant, empties when free with nothing to send.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wb_valid <= 1'b0;
      r_wb_src   <= '0;
      r_wb_tag   <= '0;
      r_wb_data  <= '0;
      r_wb_addr  <= '0;
    end else if (flush) begin
      r_wb_valid <= 1'b0;
    end else if (w_free) begin
      r_wb_valid <= w_any;
      if (w_any) begin
        r_wb_src  <= 3'(w_idx);
        r_wb_tag  <= r_tag[w_idx];
        r_wb_data <= r_data[w_idx];
        r_wb_addr <= r_addr[w_idx];
      end
    end
  end

  assign wb_valid = r_wb_valid;
  assign wb_src   = r_wb_src;
  assign wb_tag   = r_wb_tag;
  assign wb_data  = r_wb_data;
  assign wb_addr  = r_wb_addr;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: inputs driven on the falling edge, registered outputs
// checked on the falling edge, combinational req_ready checked 1 ns after inputs settle.
module tb_wb_arbiter;
  localparam int N  = 5;
  localparam int TW = 4;
  localparam int DW = 32;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req_valid;
  logic [N-1:0]  req_ready;
  logic [N*TW-1:0] req_tag;
  logic [N*DW-1:0] req_data;
  logic [N*AW-1:0] req_addr;
  logic          flush;
  logic          wb_valid;
  logic          wb_ready;
  logic [2:0]    wb_src;
  logic [TW-1:0] wb_tag;
  logic [DW-1:0] wb_data;
  logic [AW-1:0] wb_addr;

  int total = 0;
  int bad   = 0;

  wb_arbiter #(.N_REQ(N), .TAG_W(TW), .DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_tag(req_tag), .req_data(req_data), .req_addr(req_addr),
    .flush(flush),
    .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_src(wb_src), .wb_tag(wb_tag), .wb_data(wb_data), .wb_addr(wb_addr)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] exp_data(input int i, input logic [3:0] tag);
    return 32'hD000_0000 + 32'(i * 256) + 32'(tag);
  endfunction

  function automatic logic [AW-1:0] exp_addr(input int i, input logic [3:0] tag);
    return 32'hA000_0000 + 32'(i * 256) + 32'(tag);
  endfunction

  task automatic drive(input int i, input logic [3:0] tag);
    req_valid[i]           = 1'b1;
    req_tag[i*TW +: TW]    = tag;
    req_data[i*DW +: DW]   = exp_data(i, tag);
    req_addr[i*AW +: AW]   = exp_addr(i, tag);
  endtask

  task automatic idle();
    req_valid = '0;
  endtask

  task automatic test_reset();
    rst = 1'b0; flush = 1'b0; wb_ready = 1'b0;
    req_valid = '0; req_tag = '0; req_data = '0; req_addr = '0;
    #12;
    total++;
    if (wb_valid !== 1'b0) begin bad++; $display("FAIL reset_wb_valid got=%b want=0", wb_valid); end
    total++;
    if ({wb_src, wb_tag, wb_data, wb_addr} !== '0) begin
      bad++; $display("FAIL reset_payload got src=%0d tag=%h data=%h addr=%h want all 0", wb_src, wb_tag, wb_data, wb_addr);
    end
    total++;
    if (req_ready !== 5'b11111) begin bad++; $display("FAIL reset_req_ready got=%b want=11111", req_ready); end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_round_robin();
    @(negedge clk);
    wb_ready = 1'b1;
    for (int i = 0; i < N; i++) drive(i, 4'(i + 1));
    #1;
    total++;
    if (req_ready !== 5'b11111) begin bad++; $display("FAIL rr_accept_all got=%b want=11111", req_ready); end
    @(negedge clk);
    idle();
    total++;
    if (wb_valid !== 1'b0) begin bad++; $display("FAIL rr_latency got wb_valid=%b want=0", wb_valid); end
    #1;
    total++;
    if (req_ready !== 5'b00001) begin bad++; $display("FAIL rr_ready_grant0 got=%b want=00001", req_ready); end
    for (int k = 0; k < N; k++) begin
      @(negedge clk);
      total++;
      if (wb_valid !== 1'b1 || wb_src !== 3'(k) || wb_tag !== 4'(k + 1) ||
          wb_data !== exp_data(k, 4'(k + 1)) || wb_addr !== exp_addr(k, 4'(k + 1))) begin
        bad++;
        $display("FAIL rr_seq%0d got v=%b src=%0d tag=%h data=%h want v=1 src=%0d tag=%h data=%h",
                 k, wb_valid, wb_src, wb_tag, wb_data, k, 4'(k + 1), exp_data(k, 4'(k + 1)));
      end
    end
    @(negedge clk);
    total++;
    if (wb_valid !== 1'b0) begin bad++; $display("FAIL rr_drain got wb_valid=%b want=0", wb_valid); end
  endtask

  task automatic test_rr_ptr();
    drive(2, 4'h7);
    @(negedge clk);
    idle(); drive(0, 4'h1); drive(4, 4'h5);
    @(negedge clk);
    idle();
    total++;
    if (wb_valid !== 1'b1 || wb_src !== 3'd2 || wb_tag !== 4'h7) begin
      bad++; $display("FAIL ptr_first got v=%b src=%0d tag=%h want v=1 src=2 tag=7", wb_valid, wb_src, wb_tag);
    end
    @(negedge clk);
    total++;
    if (wb_valid !== 1'b1 || wb_src !== 3'd4 || wb_tag !== 4'h5) begin
      bad++; $display("FAIL ptr_wrap4 got v=%b src=%0d tag=%h want v=1 src=4 tag=5", wb_valid, wb_src, wb_tag);
    end
    @(negedge clk);
    total++;
    if (wb_valid !== 1'b1 || wb_src !== 3'd0 || wb_tag !== 4'h1) begin
      bad++; $display("FAIL ptr_wrap0 got v=%b src=%0d tag=%h want v=1 src=0 tag=1", wb_valid, wb_src, wb_tag);
    end
    @(negedge clk);
    total++;
    if (wb_valid !== 1'b0) begin bad++; $display("FAIL ptr_drain got wb_valid=%b want=0", wb_valid); end
  endtask

  task automatic test_backpressure();
    logic [3:0] next_tag;
    logic       rdy;
    int         acc;
    next_tag = 4'd1; acc = 0;
    wb_ready = 1'b0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      drive(0, next_tag);
      #1;
      rdy = req_ready[0];
      if (cyc >= 2) begin
        total++;
        if (wb_valid !== 1'b1 || wb_tag !== 4'd1) begin
          bad++; $display("FAIL bp_hold%0d got v=%b tag=%h want v=1 tag=1", cyc, wb_valid, wb_tag);
        end
      end
      if (cyc == 9) begin
        total++;
        if (rdy !== 1'b0) begin bad++; $display("FAIL bp_ready_low got=%b want=0", rdy); end
      end
      @(negedge clk);
      if (rdy) begin acc++; next_tag = next_tag + 4'd1; end
    end
    total++;
    if (acc != 2) begin bad++; $display("FAIL bp_absorbed got=%0d want=2", acc); end
    idle();
    wb_ready = 1'b1;
    @(negedge clk);
    total++;
    if (wb_valid !== 1'b1 || wb_tag !== 4'd2 || wb_src !== 3'd0) begin
      bad++; $display("FAIL bp_second got v=%b src=%0d tag=%h want v=1 src=0 tag=2", wb_valid, wb_src, wb_tag);
    end
    @(negedge clk);
    total++;
    if (wb_valid !== 1'b0) begin bad++; $display("FAIL bp_drain got wb_valid=%b want=0", wb_valid); end
  endtask

  task automatic test_back_to_back();
    wb_ready = 1'b1;
    for (int k = 0; k < 18; k++) begin
      if (k < 16) drive(4, 4'(k)); else idle();
      #1;
      if (k < 16) begin
        total++;
        if (req_ready[4] !== 1'b1) begin bad++; $display("FAIL b2b_ready%0d got=%b want=1", k, req_ready[4]); end
      end
      if (k >= 2) begin
        total++;
        if (wb_valid !== 1'b1 || wb_src !== 3'd4 || wb_tag !== 4'(k - 2)) begin
          bad++; $display("FAIL b2b_tag%0d got v=%b src=%0d tag=%h want v=1 src=4 tag=%h",
                          k, wb_valid, wb_src, wb_tag, 4'(k - 2));
        end
      end
      @(negedge clk);
    end
    total++;
    if (wb_valid !== 1'b0) begin bad++; $display("FAIL b2b_drain got wb_valid=%b want=0", wb_valid); end
  endtask

  task automatic test_flush();
    wb_ready = 1'b0;
    drive(1, 4'h3); drive(2, 4'h4); drive(3, 4'h5);
    @(negedge clk);
    idle(); drive(0, 4'h6);
    @(negedge clk);
    idle();
    total++;
    if (wb_valid !== 1'b1 || wb_src !== 3'd1 || wb_tag !== 4'h3) begin
      bad++; $display("FAIL flush_setup got v=%b src=%0d tag=%h want v=1 src=1 tag=3", wb_valid, wb_src, wb_tag);
    end
    flush = 1'b1;
    drive(4, 4'h9);
    #1;
    total++;
    if (req_ready !== 5'b00000) begin bad++; $display("FAIL flush_ready got=%b want=00000", req_ready); end
    @(negedge clk);
    flush = 1'b0; idle(); wb_ready = 1'b1;
    total++;
    if (wb_valid !== 1'b0) begin bad++; $display("FAIL flush_valid got=%b want=0", wb_valid); end
    #1;
    total++;
    if (req_ready !== 5'b11111) begin bad++; $display("FAIL flush_slots_empty got=%b want=11111", req_ready); end
    @(negedge clk);
    total++;
    if (wb_valid !== 1'b0) begin bad++; $display("FAIL flush_no_capture got wb_valid=%b src=%0d want=0", wb_valid, wb_src); end
  endtask

  task automatic test_async_reset();
    wb_ready = 1'b0;
    drive(3, 4'hC);
    @(negedge clk);
    idle(); drive(1, 4'h2); drive(2, 4'h3);
    @(negedge clk);
    idle();
    total++;
    if (wb_valid !== 1'b1 || wb_src !== 3'd3 || wb_tag !== 4'hC) begin
      bad++; $display("FAIL arst_setup got v=%b src=%0d tag=%h want v=1 src=3 tag=c", wb_valid, wb_src, wb_tag);
    end
    #2;
    rst = 1'b0;
    #1;
    total++;
    if (wb_valid !== 1'b0 || {wb_src, wb_tag, wb_data, wb_addr} !== '0) begin
      bad++; $display("FAIL arst_clear got v=%b src=%0d tag=%h data=%h want all 0", wb_valid, wb_src, wb_tag, wb_data);
    end
    total++;
    if (req_ready !== 5'b11111) begin bad++; $display("FAIL arst_ready got=%b want=11111", req_ready); end
    @(negedge clk);
    rst = 1'b1;
    wb_ready = 1'b1;
    drive(1, 4'h1); drive(4, 4'h2);
    @(negedge clk);
    idle();
    @(negedge clk);
    total++;
    if (wb_valid !== 1'b1 || wb_src !== 3'd1 || wb_tag !== 4'h1) begin
      bad++; $display("FAIL arst_first got v=%b src=%0d tag=%h want v=1 src=1 tag=1", wb_valid, wb_src, wb_tag);
    end
    @(negedge clk);
    total++;
    if (wb_valid !== 1'b1 || wb_src !== 3'd4 || wb_tag !== 4'h2) begin
      bad++; $display("FAIL arst_second got v=%b src=%0d tag=%h want v=1 src=4 tag=2", wb_valid, wb_src, wb_tag);
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_rr_ptr();
    test_backpressure();
    test_back_to_back();
    test_flush();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
